// File: rtl/clock_pkg.sv
// clock_pkg: shared constants and run-state encoding for the game clock generator.
package clock_pkg;

  localparam int HALF_DEF_C = 5;
  localparam int HALF_W_C   = 16;
  localparam int CYC_W_C    = 32;

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    DRAINING,
    STEPPING
  } run_state_t;

endpackage

// File: rtl/clock_if.sv
// clock_if: control/status bundle of the game clock generator.
// The step request is only present when CLOCK_STEP_EN is defined.
interface clock_if #(
  parameter int HALF_W = clock_pkg::HALF_W_C
);
  import clock_pkg::*;

  logic                en;
  logic                div_load;
  logic [HALF_W-1:0]   div_val;
`ifdef CLOCK_STEP_EN
  logic                step;
`endif
  logic                tick;
  logic [CYC_W_C-1:0]  cycles;
  logic                running;

`ifdef CLOCK_STEP_EN
  modport master (output en, div_load, div_val, step, input tick, cycles, running);
  modport slave  (input en, div_load, div_val, step, output tick, cycles, running);
`else
  modport master (output en, div_load, div_val, input tick, cycles, running);
  modport slave  (input en, div_load, div_val, output tick, cycles, running);
`endif

endinterface

// File: rtl/clock_halfcnt.sv
// clock_halfcnt: half-period counter running 0..max(half,1)-1 with a terminal-count flag.
module clock_halfcnt
  import clock_pkg::*;
#(
  parameter int HALF_W = HALF_W_C
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              run,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  output logic              tc
);

  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] last;

  // A half-period of zero behaves as one, so every count is terminal.
  assign last = (half == '0) ? '0 : half - HALF_W'(1);
  assign tc   = (cnt >= last);

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tc ? '0 : cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/clock.sv
// clock: game clock generator; clk = clk_ref / (2*max(half,1)) with tick pulse and rise counter.
// Define CLOCK_STEP_EN to compile in single-period stepping through io.step.
module clock
  import clock_pkg::*;
#(
  parameter int HALF_DEF = HALF_DEF_C,
  parameter int HALF_W   = HALF_W_C
) (
  input  logic   clk_ref,
  input  logic   rst,
  output logic   clk,
  clock_if.slave io
);

  localparam logic [HALF_W-1:0] HALF_RST = HALF_W'(HALF_DEF);

  run_state_t         state;
  run_state_t         state_d;
  logic               clk_q;
  logic               clk_d;
  logic               tick_q;
  logic               toggle;
  logic               stop_now;
  logic               run;
  logic               tc;
  logic               rise;
  logic [HALF_W-1:0]  half_act;
  logic [HALF_W-1:0]  half_pend;
  logic [CYC_W_C-1:0] cyc_q;

  assign run  = (state != STOPPED);
  assign rise = ~clk_q & clk_d;

  clock_halfcnt #(
    .HALF_W (HALF_W)
  ) u_halfcnt (
    .clk_ref (clk_ref),
    .rst     (rst),
    .run     (run),
    .clr     (stop_now),
    .half    (half_act),
    .tc      (tc)
  );

  // A stop request during a high phase drains it fully; during a low phase it stops at once.
  always_comb begin
    state_d  = state;
    clk_d    = clk_q;
    toggle   = 1'b0;
    stop_now = 1'b0;
    case (state)
      STOPPED: begin
        if (io.en) begin
          state_d = RUNNING;
        end
`ifdef CLOCK_STEP_EN
        else if (io.step) begin
          state_d = STEPPING;
          clk_d   = 1'b1;
          toggle  = 1'b1;
        end
`endif
      end
      RUNNING: begin
        if (tc) begin
          clk_d  = ~clk_q;
          toggle = 1'b1;
        end
        if (!io.en) begin
          if (clk_q) begin
            state_d = tc ? STOPPED : DRAINING;
          end else if (tc) begin
            state_d = DRAINING;
          end else begin
            state_d  = STOPPED;
            stop_now = 1'b1;
          end
        end
      end
      DRAINING: begin
        if (tc) begin
          clk_d   = 1'b0;
          toggle  = 1'b1;
          state_d = STOPPED;
        end
      end
`ifdef CLOCK_STEP_EN
      STEPPING: begin
        if (tc) begin
          if (clk_q) begin
            clk_d  = 1'b0;
            toggle = 1'b1;
          end else begin
            state_d = STOPPED;
          end
        end
      end
`endif
      default: state_d = STOPPED;
    endcase
  end

  // New half-periods take effect only on a clk toggle so phases are never cut short.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state     <= STOPPED;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      cyc_q     <= '0;
      half_act  <= HALF_RST;
      half_pend <= HALF_RST;
    end else begin
      state  <= state_d;
      clk_q  <= clk_d;
      tick_q <= rise;
      cyc_q  <= cyc_q + CYC_W_C'(rise);
      if (toggle) begin
        half_act <= half_pend;
      end
      if (io.div_load) begin
        half_pend <= io.div_val;
      end
    end
  end

  assign clk        = clk_q;
  assign io.tick    = tick_q;
  assign io.cycles  = cyc_q;
  assign io.running = run;

endmodule

// File: tb/tb_clock.sv
// tb_clock: self-checking bench for the clock generator against a phase-timing model.
// Define CLOCK_STEP_EN to also exercise single-step behaviour.
module tb_clock;
  import clock_pkg::*;

  localparam int H = 5;

  logic clk_ref = 1'b0;
  logic rst;
  logic gclk;
  int   checks = 0;
  int   errors = 0;

  clock_if #(.HALF_W(16)) bus ();

  clock #(
    .HALF_DEF (H),
    .HALF_W   (16)
  ) dut (
    .clk_ref (clk_ref),
    .rst     (rst),
    .clk     (gclk),
    .io      (bus.slave)
  );

  always #5 clk_ref = ~clk_ref;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Edge k counts clk_ref edges after en is first sampled high at edge 0.
  function automatic bit exp_clk(int k, int h);
    return ((k / h) % 2) == 1;
  endfunction

  function automatic bit exp_tick(int k, int h);
    return (k > 0) && (k % h == 0) && ((k / h) % 2 == 1);
  endfunction

  function automatic int exp_rises(int k, int h);
    return (k / h + 1) / 2;
  endfunction

  task automatic cyc();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
`ifdef CLOCK_STEP_EN
    bus.step     = 1'b0;
`endif
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] got;
    do_reset();
    got = {gclk, bus.tick, bus.running, bus.cycles};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got %h want %h", got, 35'd0);
    end
    repeat (8) cyc();
    got = {gclk, bus.tick, bus.running, bus.cycles};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle_without_en got %h want %h", got, 35'd0);
    end
  endtask

  task automatic test_run();
    logic [34:0] got, want;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      cyc();
      want = {exp_clk(k, H), exp_tick(k, H), 1'b1, 32'(exp_rises(k, H))};
      got  = {gclk, bus.tick, bus.running, bus.cycles};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL run k=%0d got %h want %h", k, got, want);
      end
    end
  endtask

  // Half=5 until the load of 2 at edge 7 lands at the fall on edge 10; the load of 0 lands at 22.
  function automatic bit exp_dir(int k);
    if (k < 5)   return 1'b0;
    if (k < 10)  return 1'b1;
    if (k < 22)  return (((k - 10) / 2) % 2) == 1;
    return ((k - 22) % 2) == 1;
  endfunction

  task automatic test_div_directed();
    logic [33:0] got, want;
    logic [31:0] rises;
    bit          t;
    rises = '0;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      bus.div_load = (k == 7) || (k == 20);
      bus.div_val  = (k == 7) ? 16'd2 : 16'd0;
      cyc();
      t = (k > 0) && exp_dir(k) && !exp_dir(k - 1);
      if (t) rises++;
      want = {exp_dir(k), t, rises};
      got  = {gclk, bus.tick, bus.cycles};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL div_directed k=%0d got %h want %h", k, got, want);
      end
    end
    bus.div_load = 1'b0;
  endtask

  task automatic test_div_random();
    logic [33:0] got, want;
    int          m_left, m_act, m_pend;
    bit          m_clk, m_tick, ld;
    logic [31:0] m_cyc;
    logic [15:0] val;
    do_reset();
    m_act  = H;
    m_pend = H;
    m_clk  = 1'b0;
    m_cyc  = '0;
    bus.en = 1'b1;
    cyc();
    checks++;
    if (bus.running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_random_start running got %b want 1", bus.running);
    end
    m_left = H;
    for (int n = 1; n <= 160; n++) begin
      ld  = ($urandom_range(0, 3) == 0);
      val = 16'($urandom_range(0, 3));
      bus.div_load = ld;
      bus.div_val  = val;
      cyc();
      m_tick = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_clk = !m_clk;
        if (m_clk) begin
          m_tick = 1'b1;
          m_cyc++;
        end
        m_act  = m_pend;
        m_left = (m_act == 0) ? 1 : m_act;
      end
      if (ld) m_pend = int'(val);
      want = {m_clk, m_tick, m_cyc};
      got  = {gclk, bus.tick, bus.cycles};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL div_random n=%0d got %h want %h", n, got, want);
      end
    end
    bus.div_load = 1'b0;
  endtask

  // en is first sampled low at edge d; a high phase in progress (or starting at d) runs to completion.
  task automatic test_en_drop();
    int drops[4];
    drops    = '{6, 13, 5, 0};
    drops[3] = $urandom_range(1, 40);
    foreach (drops[i]) begin
      int          d, j, s;
      logic [34:0] got, want;
      d = drops[i];
      j = d / H;
      s = (j % 2 == 1) ? (j + 1) * H : d;
      do_reset();
      for (int k = 0; k <= s + 12; k++) begin
        bus.en = (k < d);
        cyc();
        if (k < s) want = {exp_clk(k, H), exp_tick(k, H), 1'b1, 32'(exp_rises(k, H))};
        else       want = {3'b000, 32'(exp_rises(s, H))};
        got = {gclk, bus.tick, bus.running, bus.cycles};
        checks++;
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL en_drop d=%0d k=%0d got %h want %h", d, k, got, want);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [33:0] got, want;
    logic [31:0] preset;
    int          r, last;
    r      = $urandom_range(0, 2);
    preset = 32'hFFFF_FFFF - 32'(r);
    last   = H + 2 * H * r + 3;
    do_reset();
    @(negedge clk_ref);
    force dut.cyc_q = preset;
    @(negedge clk_ref);
    release dut.cyc_q;
    bus.en = 1'b1;
    for (int k = 0; k <= last; k++) begin
      cyc();
      want = {exp_tick(k, H), preset + 32'(exp_rises(k, H))};
      got  = {bus.tick, bus.cycles};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL wrap k=%0d got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] got;
    do_reset();
    bus.en = 1'b1;
    repeat (6) cyc();
    checks++;
    if ({gclk, bus.tick} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL async_pre clk/tick got %b want 11", {gclk, bus.tick});
    end
    #2;
    rst = 1'b1;
    #1;
    got = {gclk, bus.tick, bus.running, bus.cycles};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h want %h", got, 35'd0);
    end
    bus.en = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (6) cyc();
    checks++;
    if ({gclk, bus.running} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got %b want 00", {gclk, bus.running});
    end
    bus.en = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      cyc();
      checks++;
      if (gclk !== exp_clk(k, H)) begin
        errors++;
        $display("[TB] FAIL post_reset_run k=%0d got %b want %b", k, gclk, exp_clk(k, H));
      end
    end
  endtask

`ifdef CLOCK_STEP_EN
  task automatic test_step();
    logic [34:0] got, want;
    int          m;
    m = $urandom_range(1, 9);
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      bus.step = (k == 0) || (k == m);
      cyc();
      want = {k < H, k == 0, k < 2 * H, 32'd1};
      got  = {gclk, bus.tick, bus.running, bus.cycles};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL step m=%0d k=%0d got %h want %h", m, k, got, want);
      end
    end
    bus.step = 1'b0;
    do_reset();
    bus.en   = 1'b1;
    bus.step = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      cyc();
      bus.step = 1'b0;
      checks++;
      if (gclk !== exp_clk(k, H)) begin
        errors++;
        $display("[TB] FAIL step_with_en k=%0d got %b want %b", k, gclk, exp_clk(k, H));
      end
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
`ifdef CLOCK_STEP_EN
    bus.step     = 1'b0;
`endif
    test_reset();
    test_run();
    test_div_directed();
    test_div_random();
    test_en_drop();
    test_wrap();
    test_async_reset();
`ifdef CLOCK_STEP_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
